// File: rtl/fetch.sv
// fetch: instruction-fetch stage with built-in IF/ID register.
//   Owns the PC and a handshaked instruction-memory port. It presents
//   instr_fd/pcinc_fd/pcout_fd/valid_fd to decode and obeys decode's
//   stall, redirect and flush controls.
//   Ports:
//     clk, rst (async active-low)
//     pcwrite_df, write_df         stall controls from decode
//     pcsel_df, pcaddrsel_df       redirect request and target
//     flush_df                     squash IF/ID to NOP_INSTR
//     imem_req, imem_addr          memory request (held until imem_done)
//     imem_rdata, imem_done        memory response (may be same cycle)
//     instr_fd, pcinc_fd, pcout_fd, valid_fd   IF/ID register
//     err_f                        sticky fetch timeout error
//   Optional: define FETCH_TIMEOUT_EN to bound memory waits to TIMEOUT
//   cycles; without it err_f is constant 0.
module fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter int          TIMEOUT   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcwrite_df,
    input  logic        write_df,
    input  logic        pcsel_df,
    input  logic [15:0] pcaddrsel_df,
    input  logic        flush_df,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] instr_fd,
    output logic [15:0] pcinc_fd,
    output logic [15:0] pcout_fd,
    output logic        valid_fd,
    output logic        err_f
);
    typedef enum logic [2:0] {FETCH, WAIT, HOLD, DRAIN, HALTED} state_t;

    state_t      state;
    logic [15:0] pc, pc_pending, hold_instr, pc_inc;
    logic        rd_halt, hold_halt, timed_out;

    assign pc_inc    = pc + 16'd2;
    assign rd_halt   = imem_rdata[15:11] == 5'b00000;
    assign hold_halt = hold_instr[15:11] == 5'b00000;
    // Gated by rst so an in-flight request is abandoned the instant reset asserts.
    assign imem_req  = rst && (state == FETCH || state == WAIT || state == DRAIN);
    assign imem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] wait_cnt;

    assign timed_out = (state == WAIT || state == DRAIN) && !imem_done && wait_cnt == LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_f    <= 1'b0;
        end else begin
            if (timed_out)
                err_f <= 1'b1;
            wait_cnt <= ((state == WAIT || state == DRAIN) && !imem_done && !timed_out) ? wait_cnt + 1'b1 : '0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign timed_out = 1'b0;
    assign err_f     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pc_pending <= '0;
            hold_instr <= '0;
            instr_fd   <= NOP_INSTR;
            pcinc_fd   <= '0;
            pcout_fd   <= '0;
            valid_fd   <= 1'b0;
        end else begin
            case (state)
                FETCH, WAIT: begin
                    if (imem_done) begin
                        if (pcsel_df) begin
                            pc    <= pcaddrsel_df;
                            state <= FETCH;
                        end else if (!write_df) begin
                            hold_instr <= imem_rdata;
                            state      <= HOLD;
                        end else begin
                            instr_fd <= imem_rdata;
                            pcinc_fd <= pc_inc;
                            pcout_fd <= pc;
                            valid_fd <= 1'b1;
                            if (pcwrite_df)
                                pc <= pc_inc;
                            state <= rd_halt ? HALTED : FETCH;
                        end
                    end else if (pcsel_df) begin
                        // The issued request must complete before the PC may move.
                        pc_pending <= pcaddrsel_df;
                        state      <= DRAIN;
                    end else begin
                        state <= WAIT;
                    end
                end
                HOLD: begin
                    if (pcsel_df) begin
                        pc    <= pcaddrsel_df;
                        state <= FETCH;
                    end else if (write_df) begin
                        instr_fd <= hold_instr;
                        pcinc_fd <= pc_inc;
                        pcout_fd <= pc;
                        valid_fd <= 1'b1;
                        pc       <= pc_inc;
                        state    <= hold_halt ? HALTED : FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_done) begin
                        pc    <= pcsel_df ? pcaddrsel_df : pc_pending;
                        state <= FETCH;
                    end else if (pcsel_df) begin
                        pc_pending <= pcaddrsel_df;
                    end
                end
                HALTED: begin
                    if (pcsel_df) begin
                        pc    <= pcaddrsel_df;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
            // Flush wins over any load above, including a held-stall release.
            if (flush_df) begin
                instr_fd <= NOP_INSTR;
                pcinc_fd <= '0;
                pcout_fd <= '0;
                valid_fd <= 1'b0;
            end
            if (timed_out)
                state <= HALTED;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for the fetch stage with a latency-programmable memory model.
module tb_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pcwrite_df = 1'b1;
    logic        write_df = 1'b1;
    logic        pcsel_df = 1'b0;
    logic [15:0] pcaddrsel_df = 16'h0000;
    logic        flush_df = 1'b0;
    logic        imem_req, imem_done, valid_fd, err_f;
    logic [15:0] imem_addr, imem_rdata, instr_fd, pcinc_fd, pcout_fd;

    logic [7:0]  lat = 8'd0;
    logic [7:0]  wcnt;
    logic        mem_off = 1'b0;
    logic [15:0] halt_addr = 16'h0001;

    int errors = 0;
    int checks = 0;
    logic [47:0] exp_q[$];
    logic [47:0] prev_ifid = '0;
    logic        prev_v = 1'b0;

    always #5 clk = ~clk;

    fetch dut (
        .clk(clk), .rst(rst), .pcwrite_df(pcwrite_df), .write_df(write_df),
        .pcsel_df(pcsel_df), .pcaddrsel_df(pcaddrsel_df), .flush_df(flush_df),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_done(imem_done), .instr_fd(instr_fd), .pcinc_fd(pcinc_fd),
        .pcout_fd(pcout_fd), .valid_fd(valid_fd), .err_f(err_f)
    );

    function automatic logic [15:0] instr_at(input logic [15:0] a);
        return {5'b00011, a[10:0]};
    endfunction

    assign imem_rdata = (imem_addr == halt_addr) ? 16'h0000 : instr_at(imem_addr);
    assign imem_done  = imem_req && !mem_off && wcnt >= lat;

    always @(posedge clk or negedge rst)
        if (!rst) wcnt <= 8'd0;
        else      wcnt <= (!imem_req || imem_done) ? 8'd0 : wcnt + 8'd1;

    task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] ins, input logic [15:0] inc, input logic [15:0] pc);
        exp_q.push_back({ins, inc, pc});
    endtask

    task automatic redirect(input logic [15:0] tgt, input logic fl);
        pcsel_df = 1'b1; pcaddrsel_df = tgt; flush_df = fl;
        @(negedge clk);
        pcsel_df = 1'b0; flush_df = 1'b0;
    endtask

    // Every new real IF/ID content must match the next scoreboard entry.
    always @(posedge clk) begin
        #1;
        if (rst && valid_fd && (!prev_v || {instr_fd, pcinc_fd, pcout_fd} != prev_ifid)) begin
            check("ifid_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("ifid", {instr_fd, pcinc_fd, pcout_fd}, exp_q.pop_front());
        end
        prev_ifid = {instr_fd, pcinc_fd, pcout_fd};
        prev_v    = valid_fd && rst;
    end

    initial begin
        // reset state
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_instr", instr_fd, 16'h0800);
        check("rst_pcinc", pcinc_fd, 0);
        check("rst_pcout", pcout_fd, 0);
        check("rst_valid", valid_fd, 0);
        check("rst_err", err_f, 0);
        check("rst_addr", imem_addr, 16'h0000);

        // zero-latency sequential fetch, halting at 0x0008
        halt_addr = 16'h0008;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("seq_req", imem_req, 1);
            check("seq_addr", imem_addr, 16'(2 * i));
            if (i < 4) push(instr_at(16'(2 * i)), 16'(2 * i + 2), 16'(2 * i));
            else       push(16'h0000, 16'h000A, 16'h0008);
            @(negedge clk);
        end
        check("halt8_req", imem_req, 0);
        @(negedge clk);
        check("halt8_hold_req", imem_req, 0);
        check("halt8_instr", instr_fd, 16'h0000);
        check("halt8_valid", valid_fd, 1);

        // 3-cycle memory with write_df stall on the done cycle
        lat = 8'd2; halt_addr = 16'h0001;
        redirect(16'h0020, 1'b1);
        check("hold_a_addr", imem_addr, 16'h0020);
        check("hold_a_valid", valid_fd, 0);
        check("hold_a_instr", instr_fd, 16'h0800);
        @(negedge clk);
        check("hold_b_addr", imem_addr, 16'h0020);
        check("hold_b_req", imem_req, 1);
        @(negedge clk);
        write_df = 1'b0;
        @(negedge clk);
        check("hold_d_req", imem_req, 0);
        @(negedge clk);
        check("hold_e_req", imem_req, 0);
        check("hold_e_instr", instr_fd, 16'h0800);
        check("hold_e_valid", valid_fd, 0);
        write_df = 1'b1;
        push(instr_at(16'h0020), 16'h0022, 16'h0020);
        @(negedge clk);
        check("hold_next_addr", imem_addr, 16'h0022);
        check("hold_next_req", imem_req, 1);

        // redirect while waiting: old request drains, data discarded
        @(negedge clk);
        check("drain_wait_addr", imem_addr, 16'h0022);
        redirect(16'h0040, 1'b1);
        check("drain_addr", imem_addr, 16'h0022);
        check("drain_req", imem_req, 1);
        check("drain_instr", instr_fd, 16'h0800);
        check("drain_valid", valid_fd, 0);
        @(negedge clk);
        check("redir_addr", imem_addr, 16'h0040);
        check("redir_req", imem_req, 1);
        push(instr_at(16'h0040), 16'h0042, 16'h0040);
        halt_addr = 16'h0042;
        push(16'h0000, 16'h0044, 16'h0042);
        for (int n = 0; n < 20 && imem_req; n++) @(negedge clk);
        check("halt42_req", imem_req, 0);

        // HALT at 0x0010, resume at 0x0100
        lat = 8'd0; halt_addr = 16'h0010;
        push(16'h0000, 16'h0012, 16'h0010);
        redirect(16'h0010, 1'b1);
        check("halt10_addr", imem_addr, 16'h0010);
        @(negedge clk);
        check("halt10_req", imem_req, 0);
        @(negedge clk);
        check("halt10_stay", imem_req, 0);
        check("halt10_pcout", pcout_fd, 16'h0010);
        halt_addr = 16'h0100;
        push(16'h0000, 16'h0102, 16'h0100);
        redirect(16'h0100, 1'b1);
        check("resume_addr", imem_addr, 16'h0100);
        check("resume_req", imem_req, 1);
        @(negedge clk);

        // PC wrap at 0xFFFE
        halt_addr = 16'h0000;
        push(instr_at(16'hFFFE), 16'h0000, 16'hFFFE);
        push(16'h0000, 16'h0002, 16'h0000);
        redirect(16'hFFFE, 1'b1);
        check("wrap_addr", imem_addr, 16'hFFFE);
        @(negedge clk);
        check("wrap_next_addr", imem_addr, 16'h0000);
        check("wrap_pcinc", pcinc_fd, 16'h0000);
        check("wrap_pcout", pcout_fd, 16'hFFFE);
        @(negedge clk);
        check("wrap_halt_req", imem_req, 0);

        // asynchronous reset mid-WAIT
        mem_off = 1'b1; halt_addr = 16'h0001;
        redirect(16'h0200, 1'b0);
        check("arst_fetch_addr", imem_addr, 16'h0200);
        @(negedge clk);
        check("arst_wait_req", imem_req, 1);
        rst = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_addr", imem_addr, 16'h0000);
        check("arst_instr", instr_fd, 16'h0800);
        check("arst_pcinc", pcinc_fd, 0);
        check("arst_pcout", pcout_fd, 0);
        check("arst_valid", valid_fd, 0);

        // unresponsive memory: timeout only when the feature is built in
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        check("to_err", err_f, 1);
        check("to_req", imem_req, 0);
`else
        check("to_err", err_f, 0);
        check("to_req", imem_req, 1);
`endif
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage with the IF/ID pipeline register built in. Sits directly upstream of decode.
- Owns the PC, drives a handshaked instruction-memory port, and presents instr_fd/pcinc_fd/pcout_fd to decode.
- Obeys decode's stall (pcwrite_df/write_df), redirect (pcsel_df/pcaddrsel_df) and flush (flush_df) controls.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- NOP_INSTR, 16'h0800, bubble instruction placed in IF/ID on flush/reset.
- TIMEOUT, 32, max imem wait cycles before err_f (only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pcwrite_df  in  1  1 = PC may advance; 0 = hold PC.
- write_df  in  1  1 = IF/ID may load; 0 = hold IF/ID (load-use stall).
- pcsel_df  in  1  redirect request this cycle.
- pcaddrsel_df  in  16  redirect target.
- flush_df  in  1  squash IF/ID contents (load NOP_INSTR).
- imem_req  out  1  memory request valid.
- imem_addr  out  16  request address (= pc).
- imem_rdata  in  16  returned instruction.
- imem_done  in  1  response valid; may coincide with the imem_req cycle.
- instr_fd  out  16  IF/ID instruction.
- pcinc_fd  out  16  IF/ID PC+2.
- pcout_fd  out  16  IF/ID PC of instruction.
- valid_fd  out  1  IF/ID holds a real instruction.
- err_f  out  1  sticky fetch error.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=FETCH, instr_fd=NOP_INSTR, pcinc_fd=0, pcout_fd=0, valid_fd=0, err_f=0, hold buffer empty. imem_req=0 while rst=0.
- States: FETCH, WAIT, HOLD, DRAIN, HALTED.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_done=0: go to WAIT.
  - If imem_done=1: apply the accept rule below.
- WAIT:
  - imem_req and imem_addr held stable until imem_done; they must not change mid-request.
  - On imem_done: apply the accept rule.
- Accept rule, on the imem_done cycle, in priority order:
  - pcsel_df=1: discard data, pc<=pcaddrsel_df, go to FETCH.
  - write_df=0: capture rdata/pc into the hold buffer, go to HOLD; pc unchanged.
  - Otherwise: IF/ID <= {imem_rdata, pc+2, pc}, valid_fd=1. If pcwrite_df, pc<=pc+2. Next state is HALTED if imem_rdata[15:11]==5'b00000 (HALT), else FETCH.
- HOLD:
  - imem_req=0.
  - When write_df=1: load IF/ID from the hold buffer, pc<=pc+2, go to FETCH (or HALTED if the held instruction is HALT).
  - pcsel_df=1 in HOLD: drop the buffer, pc<=pcaddrsel_df, go to FETCH.
- Redirect while WAIT and imem_done=0: latch pcaddrsel_df into pc_pending, go to DRAIN.
- DRAIN:
  - Hold the original request until imem_done, discard the data, pc<=pc_pending, go to FETCH.
  - A newer pcsel_df during DRAIN overwrites pc_pending.
- HALTED:
  - imem_req=0; IF/ID holds.
  - Exits only on pcsel_df (pc<=target, go to FETCH) or reset.
- flush_df=1, independent of state: IF/ID <= {NOP_INSTR, 0, 0}, valid_fd=0.
  - flush overrides write_df=0.
  - Same-cycle accept data is discarded because flush always accompanies pcsel_df.
- pcwrite_df=0 with write_df=1 is legal: IF/ID loads, PC holds, and the same address is re-fetched.
- pc+2 wraps modulo 2^16 (16'hFFFE -> 16'h0000), no error.
- Reset mid-request: the request is abandoned and imem_req drops asynchronously. The memory model must tolerate this.
- IF/ID latency: an instruction appears on instr_fd the cycle after imem_done.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A counter increments each cycle in WAIT/DRAIN and clears on imem_done.
  - Reaching TIMEOUT sets err_f (sticky until reset), forces state HALTED and drops imem_req.
- Not defined: no counter; err_f is tied to 0; waits are unbounded.

Test Plan:
- Zero-latency memory (done same cycle), 4 sequential instrs from 0 -> imem_addr 0,2,4,6 on consecutive cycles; pcout_fd 0,2,4,6 one cycle later; valid_fd=1.
- 3-cycle memory; write_df=0 asserted on the done cycle for 2 cycles -> instr held in HOLD with imem_req=0; IF/ID unchanged for 2 cycles; then loads the held instr, next addr = pc+2.
- Redirect while WAIT to 16'h0040 -> old request held until done, data discarded; next imem_addr=16'h0040; flush gives instr_fd=16'h0800, valid_fd=0.
- Fetch 16'h0000 (HALT) at 16'h0010 -> IF/ID gets HALT, imem_req stays 0; pcsel_df to 16'h0100 -> fetch resumes at 16'h0100.
- PC=16'hFFFE fetch -> pcinc_fd=16'h0000, next addr 16'h0000; assert rst=0 mid-WAIT -> outputs return to reset values immediately.
- FETCH_TIMEOUT_EN, TIMEOUT=32, imem_done held 0 -> err_f=1 after 32 wait cycles, imem_req=0; without the macro err_f stays 0.
